alu_mul_seq: RTL and testbench

Multi-cycle unsigned multiply sequencer that time-shares the existing 32-bit ALU with the pipeline EX stage.
- While idle, the EX-stage ALU operands and control pass straight through to the ALU.
- On a multiply request, the block takes ownership of the ALU and runs a shift-add algorithm (one ALU add per cycle), stalling the pipeline.
- It returns a 2*WIDTH_D product with a one-cycle done pulse.

---
 rtl/alu_mul_seq.sv | 114 +++++++++++
 tb/tb_alu_mul_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add multiply sequencer sharing the EX-stage ALU
module alu_mul_seq #(
    parameter int WIDTH_D = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH_D-1:0] op_a,
    input  logic [WIDTH_D-1:0] op_b,
    input  logic [WIDTH_D-1:0] ex_a,
    input  logic [WIDTH_D-1:0] ex_b,
    input  logic [3:0]         ex_alu_ctrl,
    input  logic [WIDTH_D-1:0] alu_y,
    output logic [WIDTH_D-1:0] alu_a,
    output logic [WIDTH_D-1:0] alu_b,
    output logic [3:0]         alu_ctrl,
    output logic               stall,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_D-1:0] prod_hi,
    output logic [WIDTH_D-1:0] prod_lo
);

    localparam int CW = $clog2(WIDTH_D) + 1;
    localparam logic [3:0]    ALU_ADD = 4'b0010;
    localparam logic [CW-1:0] LAST    = CW'(WIDTH_D - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH_D-1:0] mcand;
    logic               carry;

    // The shared ALU exposes no carry; a wrapped sum is smaller than either addend.
    assign carry = (alu_y < prod_hi);

    always_comb begin
        state_nxt = state;
        alu_a     = ex_a;
        alu_b     = ex_b;
        alu_ctrl  = ex_alu_ctrl;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = start;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                alu_a    = prod_hi;
                alu_b    = mcand;
                alu_ctrl = ALU_ADD;
                stall    = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            mcand   <= '0;
            prod_hi <= '0;
            prod_lo <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand   <= op_a;
                        prod_hi <= '0;
                        prod_lo <= op_b;
                        cnt     <= '0;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (prod_lo[0]) begin
                        {prod_hi, prod_lo} <= {carry, alu_y, prod_lo[WIDTH_D-1:1]};
                    end else begin
                        {prod_hi, prod_lo} <= {1'b0, prod_hi, prod_lo[WIDTH_D-1:1]};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - randomized self-checking bench for alu_mul_seq
module tb_alu_mul_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [3:0]  ex_alu_ctrl;
    logic [31:0] alu_y;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] prod_hi;
    logic [31:0] prod_lo;

    int total = 0;
    int bad   = 0;

    alu_mul_seq #(.WIDTH_D(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .ex_a        (ex_a),
        .ex_b        (ex_b),
        .ex_alu_ctrl (ex_alu_ctrl),
        .alu_y       (alu_y),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .prod_hi     (prod_hi),
        .prod_lo     (prod_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared ALU: add on 0010, something unrelated otherwise.
    always_comb begin
        alu_y = alu_a ^ alu_b;
        if (alu_ctrl == 4'b0010) begin
            alu_y = alu_a + alu_b;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register contents after k iterations: partial product sits above the unshifted multiplier bits.
    function automatic logic [63:0] partial(input logic [31:0] a, input logic [31:0] b, input int k);
        logic [63:0] low_bits;
        low_bits = 64'(b) & ((64'd1 << k) - 64'd1);
        return ((64'(a) * low_bits) << (32 - k)) | (64'(b) >> k);
    endfunction

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit disturb);
        logic [63:0] exp_reg;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        #1;
        check("accept_stall", 64'(stall), 64'd1);
        check("accept_busy", 64'(busy), 64'd0);
        tick();
        for (int k = 0; k < 32; k++) begin
            if (disturb) begin
                op_a  = $urandom;
                op_b  = $urandom;
                start = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            #1;
            exp_reg = partial(a, b, k);
            check("run_busy", 64'(busy), 64'd1);
            check("run_stall", 64'(stall), 64'd1);
            check("run_done", 64'(done), 64'd0);
            check("run_ctrl", 64'(alu_ctrl), 64'd2);
            check("run_alu_a", 64'(alu_a), 64'(exp_reg[63:32]));
            check("run_alu_b", 64'(alu_b), 64'(a));
            tick();
        end
        start = disturb;
        #1;
        check("done_pulse", 64'(done), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("done_stall", 64'(stall), 64'd0);
        check("done_pass_a", 64'(alu_a), 64'(ex_a));
        check("done_pass_ctrl", 64'(alu_ctrl), 64'(ex_alu_ctrl));
        check("product", {prod_hi, prod_lo}, 64'(a) * 64'(b));
        start = 1'b0;
        tick();
        check("after_done", 64'(done), 64'd0);
        check("after_busy", 64'(busy), 64'd0);
        check("product_hold", {prod_hi, prod_lo}, 64'(a) * 64'(b));
    endtask

    initial begin
        int          ndone;
        logic [31:0] ra;
        logic [31:0] rb;
        rst         = 1'b1;
        start       = 1'b0;
        op_a        = '0;
        op_b        = '0;
        ex_a        = '0;
        ex_b        = '0;
        ex_alu_ctrl = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_prod", {prod_hi, prod_lo}, 64'd0);
        check("reset_stall", 64'(stall), 64'd0);

        ex_a        = 32'd7;
        ex_b        = 32'd9;
        ex_alu_ctrl = 4'b0110;
        #1;
        check("pass_a", 64'(alu_a), 64'd7);
        check("pass_b", 64'(alu_b), 64'd9);
        check("pass_ctrl", 64'(alu_ctrl), 64'h6);
        check("pass_stall", 64'(stall), 64'd0);

        do_mul(32'd3, 32'd5, 1'b0);
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        do_mul(32'h12345678, 32'h10, 1'b1);
        do_mul(32'd0, 32'd0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            ex_a        = $urandom;
            ex_b        = $urandom;
            ex_alu_ctrl = 4'($urandom);
            #1;
            check("rand_pass_a", 64'(alu_a), 64'(ex_a));
            check("rand_pass_b", 64'(alu_b), 64'(ex_b));
            check("rand_pass_ctrl", 64'(alu_ctrl), 64'(ex_alu_ctrl));
            check("rand_pass_stall", 64'(stall), 64'd0);
            tick();
        end

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) rb = 32'h80000001;
            do_mul(ra, rb, 1'($urandom));
        end

        // Abort mid-RUN with reset
        op_a  = $urandom;
        op_b  = $urandom;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        rst   = 1'b1;
        start = 1'($urandom);
        tick();
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_prod", {prod_hi, prod_lo}, 64'd0);
        check("abort_stall_lo", 64'(stall), 64'd0);
        start = 1'b1;
        #1;
        check("abort_stall_hi", 64'(stall), 64'd1);
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);

        // Back-to-back with start held high
        op_a  = 32'd0;
        op_b  = 32'hFFFFFFFF;
        start = 1'b1;
        tick();
        ndone = 0;
        for (int c = 1; c <= 75; c++) begin
            if (c == 5) begin
                op_a = 32'd2;
                op_b = 32'd3;
            end
            #1;
            if (done) begin
                ndone++;
                check("b2b_stall", 64'(stall), 64'd0);
                if (ndone == 1) begin
                    check("b2b_first_cycle", 64'(c), 64'd33);
                    check("b2b_first_prod", {prod_hi, prod_lo}, 64'd0);
                end else begin
                    check("b2b_second_cycle", 64'(c), 64'd67);
                    check("b2b_second_prod", {prod_hi, prod_lo}, 64'd6);
                end
            end
            if (c == 72) start = 1'b0;
            tick();
        end
        check("b2b_done_count", 64'(ndone), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
